dm_ctrl: RTL and testbench

//  Access controller for the 4 KB word-only data memory (10-bit word address, registered read).

---
 rtl/dm_ctrl_if.sv | 33 +++
 rtl/dm_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_dm_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_ctrl_if.sv
// Bundle between the data-memory controller, its two requesters and the
// word-only data memory. The slave side is the controller.
interface dm_ctrl_if;
  logic        req0, req1;
  logic        we0, we1;
  logic [11:0] addr0, addr1;
  logic [1:0]  size0, size1;
  logic        sext0, sext1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1;
  logic        done0, done1;
  logic        err;
  logic [31:0] rdata;
  logic [9:0]  dm_addr;
  logic [31:0] dm_din;
  logic        dm_memwrite;
  logic        dm_memread;
  logic [31:0] dm_dout;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, size0, size1,
           sext0, sext1, wdata0, wdata1, dm_dout,
    output gnt0, gnt1, done0, done1, err, rdata,
           dm_addr, dm_din, dm_memwrite, dm_memread
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, size0, size1,
           sext0, sext1, wdata0, wdata1, dm_dout,
    input  gnt0, gnt1, done0, done1, err, rdata,
           dm_addr, dm_din, dm_memwrite, dm_memread
  );
endinterface

// File: rtl/dm_ctrl.sv
// Two-port access controller for the word-only data memory: arbitration,
// sub-word load extraction/extension and read-modify-write sub-word stores.
module dm_ctrl #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input logic      clk,
  input logic      rst_n,
  dm_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, WR, LD, MRG} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [31:0] wdata_q, wdata_d;
  logic        port_q, port_d;
  logic        last_q, last_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [9:0]  dm_addr_q, dm_addr_d;
  logic [31:0] dm_din_q, dm_din_d;

  logic        any_req, sel;
  logic        s_we, s_sext, illegal;
  logic [11:0] s_addr;
  logic [1:0]  s_size;
  logic [31:0] s_wdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val, merged;
  logic        gnt0, gnt1, memread, memwrite;
  logic [31:0] din_out;

  always_comb begin
    any_req = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) sel = FIXED_PRIO ? 1'b0 : ~last_q;
    else                      sel = bus.req1;
    s_we    = sel ? bus.we1    : bus.we0;
    s_addr  = sel ? bus.addr1  : bus.addr0;
    s_size  = sel ? bus.size1  : bus.size0;
    s_sext  = sel ? bus.sext1  : bus.sext0;
    s_wdata = sel ? bus.wdata1 : bus.wdata0;
    illegal = (s_size == 2'b11) ||
              (s_size == 2'b01 && s_addr[0]) ||
              (s_size == 2'b10 && s_addr[1:0] != 2'b00);
  end

  // Lane extraction for loads and lane replacement for sub-word stores.
  always_comb begin
    byte_sel = bus.dm_dout[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? bus.dm_dout[31:16] : bus.dm_dout[15:0];
    load_val = bus.dm_dout;
    merged   = bus.dm_dout;
    case (size_q)
      2'b00: begin
        load_val = {{24{sext_q & byte_sel[7]}}, byte_sel};
        merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_val = {{16{sext_q & half_sel[15]}}, half_sel};
        if (lane_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: begin
        load_val = bus.dm_dout;
        merged   = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    lane_d    = lane_q;
    size_d    = size_q;
    sext_d    = sext_q;
    wdata_d   = wdata_q;
    port_d    = port_q;
    last_d    = last_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    dm_addr_d = dm_addr_q;
    dm_din_d  = dm_din_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    din_out   = dm_din_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt0    = ~sel;
          gnt1    = sel;
          last_d  = sel;
          port_d  = sel;
          we_d    = s_we;
          lane_d  = s_addr[1:0];
          size_d  = s_size;
          sext_d  = s_sext;
          wdata_d = s_wdata;
          if (illegal) begin
            err_d   = 1'b1;
            done0_d = ~sel;
            done1_d = sel;
          end else begin
            dm_addr_d = s_addr[11:2];
            if (s_we && s_size == 2'b10) begin
              state_d  = WR;
              dm_din_d = s_wdata;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD: begin
        memread = 1'b1;
        state_d = we_q ? MRG : LD;
      end
      LD: begin
        rdata_d = load_val;
        done0_d = ~port_q;
        done1_d = port_q;
        state_d = IDLE;
      end
      WR: begin
        memwrite = 1'b1;
        done0_d  = ~port_q;
        done1_d  = port_q;
        state_d  = IDLE;
      end
      MRG: begin
        // Merged word goes out combinationally while dm_dout is valid; the
        // register keeps it so dm_din holds afterwards.
        memwrite = 1'b1;
        din_out  = merged;
        dm_din_d = merged;
        done0_d  = ~port_q;
        done1_d  = port_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      lane_q    <= '0;
      size_q    <= '0;
      sext_q    <= 1'b0;
      wdata_q   <= '0;
      port_q    <= 1'b0;
      last_q    <= 1'b1;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      dm_addr_q <= '0;
      dm_din_q  <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      lane_q    <= lane_d;
      size_q    <= size_d;
      sext_q    <= sext_d;
      wdata_q   <= wdata_d;
      port_q    <= port_d;
      last_q    <= last_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      dm_addr_q <= dm_addr_d;
      dm_din_q  <= dm_din_d;
    end
  end

  assign bus.gnt0        = gnt0;
  assign bus.gnt1        = gnt1;
  assign bus.done0       = done0_q;
  assign bus.done1       = done1_q;
  assign bus.err         = err_q;
  assign bus.rdata       = rdata_q;
  assign bus.dm_addr     = dm_addr_q;
  assign bus.dm_din      = din_out;
  assign bus.dm_memwrite = memwrite;
  assign bus.dm_memread  = memread;

endmodule

// File: tb/tb_dm_ctrl.sv
// Scoreboard bench for dm_ctrl: a round-robin instance with a behavioural
// memory, and a fixed-priority instance used for arbitration only.
module tb_dm_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dm_ctrl_if bus ();
  dm_ctrl_if bus2 ();

  dm_ctrl #(.FIXED_PRIO(1'b0)) u_dut    (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  dm_ctrl #(.FIXED_PRIO(1'b1)) u_dut_fp (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (bus.dm_memwrite) mem[bus.dm_addr] <= bus.dm_din;
    if (bus.dm_memread)  bus.dm_dout <= mem[bus.dm_addr];
  end

  typedef struct packed {
    logic        port;
    logic        err;
    logic        load;
    logic [31:0] rdata;
    logic [3:0]  lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   passes = 0;
  logic tb_last = 1'b1;

  int          r_glat, r_dlat, r_nrd, r_nwr, r_both;
  logic        r_port, r_err;
  logic [31:0] r_rd;

  task automatic access(input logic p, input logic we, input logic [11:0] a,
                        input logic [1:0] sz, input logic sx, input logic [31:0] wd);
    r_glat = -1; r_dlat = -1; r_nrd = 0; r_nwr = 0; r_both = 0;
    r_port = 1'b0; r_err = 1'b0; r_rd = '0;
    @(posedge clk); #1;
    if (p) begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.size1 = sz; bus.sext1 = sx; bus.wdata1 = wd;
    end else begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.size0 = sz; bus.sext0 = sx; bus.wdata0 = wd;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (p ? bus.gnt1 : bus.gnt0) begin r_glat = i; tb_last = p; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      r_nrd += int'(bus.dm_memread);
      r_nwr += int'(bus.dm_memwrite);
      if (bus.dm_memread && bus.dm_memwrite) r_both++;
      if (bus.done0 || bus.done1) begin
        r_dlat = i; r_port = bus.done1; r_err = bus.err; r_rd = bus.rdata;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err} !== 5'b0)
      $display("FAIL rst_ctl got=%b exp=00000", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err}); else passes++;
    checks++; if ({bus.dm_memread, bus.dm_memwrite} !== 2'b00)
      $display("FAIL rst_strobe got=%b exp=00", {bus.dm_memread, bus.dm_memwrite}); else passes++;
    checks++; if (bus.rdata !== 32'h0) $display("FAIL rst_rdata got=%h exp=0", bus.rdata); else passes++;
    checks++; if (bus.dm_addr !== 10'h0 || bus.dm_din !== 32'h0)
      $display("FAIL rst_dm got=%h/%h exp=0/0", bus.dm_addr, bus.dm_din); else passes++;
  endtask

  task automatic test_word;
    sb.push_back('{port:1'b0, err:1'b0, load:1'b0, rdata:32'h0, lat:4'd2});
    access(1'b0, 1'b1, 12'h010, 2'b10, 1'b0, 32'hDEADBEEF);
    e = sb.pop_front();
    checks++; if (r_glat !== 0) $display("FAIL sw_gnt got=%0d exp=0", r_glat); else passes++;
    checks++; if (r_dlat !== int'(e.lat)) $display("FAIL sw_lat got=%0d exp=%0d", r_dlat, e.lat); else passes++;
    checks++; if (r_port !== e.port || r_err !== e.err) $display("FAIL sw_port_err got=%b%b exp=%b%b", r_port, r_err, e.port, e.err); else passes++;
    checks++; if (mem[4] !== 32'hDEADBEEF) $display("FAIL sw_mem got=%h exp=deadbeef", mem[4]); else passes++;
    sb.push_back('{port:1'b0, err:1'b0, load:1'b1, rdata:32'hDEADBEEF, lat:4'd3});
    access(1'b0, 1'b0, 12'h010, 2'b10, 1'b0, 32'h0);
    e = sb.pop_front();
    checks++; if (r_dlat !== int'(e.lat)) $display("FAIL lw_lat got=%0d exp=%0d", r_dlat, e.lat); else passes++;
    checks++; if (r_rd !== e.rdata) $display("FAIL lw_rdata got=%h exp=%h", r_rd, e.rdata); else passes++;
  endtask

  task automatic test_byte;
    access(1'b0, 1'b1, 12'h010, 2'b10, 1'b0, 32'h11223344);
    sb.push_back('{port:1'b0, err:1'b0, load:1'b0, rdata:32'h0, lat:4'd3});
    access(1'b0, 1'b1, 12'h012, 2'b00, 1'b0, 32'hFFFFFFA5);
    e = sb.pop_front();
    checks++; if (r_dlat !== int'(e.lat)) $display("FAIL sb_lat got=%0d exp=%0d", r_dlat, e.lat); else passes++;
    checks++; if (r_nrd !== 1 || r_nwr !== 1) $display("FAIL sb_strobes got=%0d/%0d exp=1/1", r_nrd, r_nwr); else passes++;
    checks++; if (mem[4] !== 32'h11A53344) $display("FAIL sb_mem got=%h exp=11a53344", mem[4]); else passes++;
    sb.push_back('{port:1'b0, err:1'b0, load:1'b1, rdata:32'hFFFFFFA5, lat:4'd3});
    access(1'b0, 1'b0, 12'h012, 2'b00, 1'b1, 32'h0);
    e = sb.pop_front();
    checks++; if (r_rd !== e.rdata || r_dlat !== int'(e.lat)) $display("FAIL lb_rdata got=%h@%0d exp=%h@%0d", r_rd, r_dlat, e.rdata, e.lat); else passes++;
    sb.push_back('{port:1'b1, err:1'b0, load:1'b1, rdata:32'h000000A5, lat:4'd3});
    access(1'b1, 1'b0, 12'h012, 2'b00, 1'b0, 32'h0);
    e = sb.pop_front();
    checks++; if (r_rd !== e.rdata) $display("FAIL lbu_rdata got=%h exp=%h", r_rd, e.rdata); else passes++;
    checks++; if (r_port !== e.port) $display("FAIL lbu_port got=%b exp=%b", r_port, e.port); else passes++;
  endtask

  task automatic test_half;
    access(1'b1, 1'b1, 12'h020, 2'b10, 1'b0, 32'h00000000);
    sb.push_back('{port:1'b1, err:1'b0, load:1'b0, rdata:32'h0, lat:4'd3});
    access(1'b1, 1'b1, 12'h022, 2'b01, 1'b0, 32'h00008001);
    e = sb.pop_front();
    checks++; if (r_dlat !== int'(e.lat) || r_port !== e.port) $display("FAIL sh_lat got=%0d/%b exp=%0d/%b", r_dlat, r_port, e.lat, e.port); else passes++;
    checks++; if (mem[8] !== 32'h80010000) $display("FAIL sh_mem got=%h exp=80010000", mem[8]); else passes++;
    sb.push_back('{port:1'b0, err:1'b0, load:1'b1, rdata:32'hFFFF8001, lat:4'd3});
    access(1'b0, 1'b0, 12'h022, 2'b01, 1'b1, 32'h0);
    e = sb.pop_front();
    checks++; if (r_rd !== e.rdata) $display("FAIL lh_rdata got=%h exp=%h", r_rd, e.rdata); else passes++;
    sb.push_back('{port:1'b0, err:1'b0, load:1'b1, rdata:32'h00003344, lat:4'd3});
    access(1'b0, 1'b0, 12'h010, 2'b01, 1'b1, 32'h0);
    e = sb.pop_front();
    checks++; if (r_rd !== e.rdata) $display("FAIL lh_low_rdata got=%h exp=%h", r_rd, e.rdata); else passes++;
  endtask

  task automatic test_illegal;
    sb.push_back('{port:1'b1, err:1'b1, load:1'b1, rdata:32'h00003344, lat:4'd1});
    access(1'b1, 1'b0, 12'h006, 2'b10, 1'b0, 32'h0);
    e = sb.pop_front();
    checks++; if (r_dlat !== int'(e.lat) || r_err !== e.err || r_port !== e.port)
      $display("FAIL ill_word got=%0d/%b/%b exp=%0d/%b/%b", r_dlat, r_err, r_port, e.lat, e.err, e.port); else passes++;
    checks++; if (r_rd !== e.rdata) $display("FAIL ill_word_rdata got=%h exp=%h", r_rd, e.rdata); else passes++;
    checks++; if (r_nrd + r_nwr !== 0) $display("FAIL ill_word_strobe got=%0d exp=0", r_nrd + r_nwr); else passes++;
    sb.push_back('{port:1'b0, err:1'b1, load:1'b0, rdata:32'h00003344, lat:4'd1});
    access(1'b0, 1'b1, 12'h010, 2'b11, 1'b0, 32'h12345678);
    e = sb.pop_front();
    checks++; if (r_dlat !== int'(e.lat) || r_err !== e.err || r_nwr !== 0)
      $display("FAIL ill_size got=%0d/%b/%0d exp=%0d/%b/0", r_dlat, r_err, r_nwr, e.lat, e.err); else passes++;
    checks++; if (mem[4] !== 32'h11A53344) $display("FAIL ill_size_mem got=%h exp=11a53344", mem[4]); else passes++;
    sb.push_back('{port:1'b0, err:1'b1, load:1'b1, rdata:32'h00003344, lat:4'd1});
    access(1'b0, 1'b0, 12'h023, 2'b01, 1'b0, 32'h0);
    e = sb.pop_front();
    checks++; if (r_err !== e.err || r_rd !== e.rdata) $display("FAIL ill_half got=%b/%h exp=%b/%h", r_err, r_rd, e.err, e.rdata); else passes++;
    sb.push_back('{port:1'b0, err:1'b0, load:1'b1, rdata:32'h80010000, lat:4'd3});
    access(1'b0, 1'b0, 12'h020, 2'b10, 1'b0, 32'h0);
    e = sb.pop_front();
    checks++; if (r_err !== e.err || r_rd !== e.rdata) $display("FAIL post_ill_load got=%b/%h exp=%b/%h", r_err, r_rd, e.err, e.rdata); else passes++;
  endtask

  task automatic test_back_to_back;
    int n, cyc, last_cyc, both, bad_seq, bad_gap, bad_data;
    logic want;
    n = 0; cyc = 0; last_cyc = 0; both = 0; bad_seq = 0; bad_gap = 0; bad_data = 0;
    want = ~tb_last;
    @(posedge clk); #1;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 12'h010; bus.size0 = 2'b10; bus.sext0 = 1'b0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 12'h020; bus.size1 = 2'b10; bus.sext1 = 1'b0;
    while ((n < 4 || sb.size() > 0) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.dm_memread && bus.dm_memwrite) both++;
      if (bus.done0 || bus.done1) begin
        e = sb.pop_front();
        if (bus.done1 !== e.port || bus.rdata !== e.rdata || bus.err !== 1'b0) bad_data++;
      end
      if (bus.gnt0 || bus.gnt1) begin
        if (bus.gnt1 !== want || (bus.gnt0 && bus.gnt1)) bad_seq++;
        if (n > 0 && cyc - last_cyc != 3) bad_gap++;
        sb.push_back('{port:bus.gnt1, err:1'b0, load:1'b1,
                       rdata:(bus.gnt1 ? 32'h80010000 : 32'h11A53344), lat:4'd3});
        tb_last = bus.gnt1;
        want = ~bus.gnt1;
        last_cyc = cyc;
        n++;
      end
      @(posedge clk); #1;
      if (n >= 4) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
    end
    checks++; if (n !== 4 || sb.size() !== 0) $display("FAIL rr_count got=%0d grants %0d pending exp=4/0", n, sb.size()); else passes++;
    checks++; if (bad_seq !== 0) $display("FAIL rr_alternate got=%0d bad exp=0", bad_seq); else passes++;
    checks++; if (bad_gap !== 0) $display("FAIL rr_back_to_back got=%0d bad gaps exp=0", bad_gap); else passes++;
    checks++; if (bad_data !== 0 || both !== 0) $display("FAIL rr_done_data got=%0d/%0d exp=0/0", bad_data, both); else passes++;
    sb.delete();
  endtask

  task automatic test_fixed_prio;
    int g, cyc, bad;
    g = 0; cyc = 0; bad = 0;
    @(posedge clk); #1;
    bus2.req0 = 1'b1; bus2.req1 = 1'b1;
    while (g < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus2.gnt0 || bus2.gnt1) begin
        if (bus2.gnt1 !== (g >= 3)) bad++;
        g++;
      end
      @(posedge clk); #1;
      if (g >= 3) bus2.req0 = 1'b0;
    end
    bus2.req1 = 1'b0;
    checks++; if (g !== 4 || bad !== 0) $display("FAIL fixed_prio got=%0d grants %0d bad exp=4/0", g, bad); else passes++;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset_mid;
    int seen_done, seen_wr, cyc;
    logic rd_seen;
    access(1'b0, 1'b1, 12'h030, 2'b10, 1'b0, 32'hCAFEBABE);
    checks++; if (mem[12] !== 32'hCAFEBABE) $display("FAIL rm_pre_mem got=%h exp=cafebabe", mem[12]); else passes++;
    @(posedge clk); #1;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 12'h031; bus.size0 = 2'b00; bus.wdata0 = 32'h00000011;
    cyc = 0;
    do begin @(negedge clk); cyc++; if (!bus.gnt0) begin @(posedge clk); #1; end end
    while (!bus.gnt0 && cyc < 20);
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rd_seen = bus.dm_memread;
    seen_done = 0; seen_wr = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen_done += int'(bus.done0) + int'(bus.done1);
      seen_wr += int'(bus.dm_memwrite);
      @(posedge clk); #1;
    end
    checks++; if (rd_seen !== 1'b1 || cyc >= 20) $display("FAIL rm_in_rd got=%b exp=1", rd_seen); else passes++;
    checks++; if (seen_done !== 0 || seen_wr !== 0) $display("FAIL rm_abort got=%0d done %0d wr exp=0/0", seen_done, seen_wr); else passes++;
    checks++; if (mem[12] !== 32'hCAFEBABE) $display("FAIL rm_mem got=%h exp=cafebabe", mem[12]); else passes++;
    tb_last = 1'b1;
    sb.push_back('{port:1'b0, err:1'b0, load:1'b1, rdata:32'hCAFEBABE, lat:4'd3});
    access(1'b0, 1'b0, 12'h030, 2'b10, 1'b0, 32'h0);
    e = sb.pop_front();
    checks++; if (r_glat !== 0 || r_dlat !== int'(e.lat) || r_rd !== e.rdata)
      $display("FAIL rm_after got=%0d/%0d/%h exp=0/%0d/%h", r_glat, r_dlat, r_rd, e.lat, e.rdata); else passes++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.size0 = '0; bus.size1 = '0;
    bus.sext0 = 1'b0; bus.sext1 = 1'b0; bus.wdata0 = '0; bus.wdata1 = '0;
    bus2.req0 = 1'b0; bus2.req1 = 1'b0; bus2.we0 = 1'b0; bus2.we1 = 1'b0;
    bus2.addr0 = 12'h040; bus2.addr1 = 12'h044; bus2.size0 = 2'b10; bus2.size1 = 2'b10;
    bus2.sext0 = 1'b0; bus2.sext1 = 1'b0; bus2.wdata0 = '0; bus2.wdata1 = '0;
    bus2.dm_dout = '0;
    repeat (3) @(posedge clk);
    test_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    test_word();
    test_byte();
    test_half();
    test_illegal();
    test_back_to_back();
    test_fixed_prio();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
